// File: rtl/mux4_rr_arbiter.sv
// Four-way round-robin arbiter feeding one registered valid/ready output word.
// A grant captures one requester's data, pulses its ack for a cycle, then waits for out_ready.
module mux4_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [3:0]       ack,
    output logic [1:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       ptr, ptr_nxt;
    logic [1:0]       idx;
    logic             found;
    logic [WIDTH-1:0] granted_word;
    logic [WIDTH-1:0] out_data_nxt;
    logic [1:0]       sel_nxt;
    logic [3:0]       ack_nxt;
    logic             out_valid_nxt;

    // Scan ptr, ptr+1, ... ; the 2-bit add wraps 3 -> 0 on its own.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        idx   = ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!found && req[ptr + 2'(k)]) begin
                idx   = ptr + 2'(k);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        case (idx)
            2'd0:    granted_word = a;
            2'd1:    granted_word = b;
            2'd2:    granted_word = c;
            default: granted_word = d;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        out_data_nxt  = out_data;
        sel_nxt       = sel;
        ack_nxt       = 4'b0000;
        out_valid_nxt = out_valid;
        case (state)
            IDLE: begin
                if (found) begin
                    out_data_nxt  = granted_word;
                    sel_nxt       = idx;
                    ack_nxt       = 4'b0001 << idx;
                    out_valid_nxt = 1'b1;
                    ptr_nxt       = idx + 2'd1;
                    state_nxt     = BUSY;
                end
            end
            BUSY: begin
                // Requests are ignored here; IDLE is always revisited before the next grant.
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            out_data  <= '0;
            sel       <= 2'd0;
            ack       <= 4'b0000;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            out_data  <= out_data_nxt;
            sel       <= sel_nxt;
            ack       <= ack_nxt;
            out_valid <= out_valid_nxt;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: vector table, directed corner sequences,
// and randomized traffic against a behavioural model.
module tb_mux4_rr_arbiter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req;
    logic [W-1:0] a, b, c, d;
    logic [3:0]   ack;
    logic [1:0]   sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    int n_tests = 0;
    int n_fail  = 0;

    mux4_rr_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .ack       (ack),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    typedef struct {
        logic [3:0]   req;
        logic         rdy;
        logic         exp_valid;
        logic [W-1:0] exp_data;
        logic [1:0]   exp_sel;
        logic [3:0]   exp_ack;
    } vec_t;

    function automatic vec_t mk(logic [3:0] r, logic y, logic v, logic [W-1:0] dt,
                                logic [1:0] s, logic [3:0] k);
        vec_t t;
        t.req = r; t.rdy = y; t.exp_valid = v; t.exp_data = dt; t.exp_sel = s; t.exp_ack = k;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic v, input logic [W-1:0] dt,
                              input logic [1:0] s, input logic [3:0] k);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".data"},  32'(out_data),  32'(dt));
        check({tag, ".sel"},   32'(sel),       32'(s));
        check({tag, ".ack"},   32'(ack),       32'(k));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: a held word is the only state besides the rotating priority.
    logic         m_valid;
    logic [W-1:0] m_data;
    logic [1:0]   m_sel;
    logic [3:0]   m_ack;
    int           m_ptr;

    task automatic model_reset();
        m_valid = 1'b0; m_data = '0; m_sel = 2'd0; m_ack = 4'b0000; m_ptr = 0;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic y, input logic [W-1:0] wa,
                              input logic [W-1:0] wb, input logic [W-1:0] wc,
                              input logic [W-1:0] wd);
        logic [W-1:0] words [4];
        int order [$];
        words[0] = wa; words[1] = wb; words[2] = wc; words[3] = wd;
        m_ack = 4'b0000;
        if (m_valid) begin
            if (y) m_valid = 1'b0;
        end else if (r != 4'b0000) begin
            for (int k = 0; k < 4; k++) order.push_back((m_ptr + k) % 4);
            foreach (order[i]) begin
                if (r[order[i]]) begin
                    m_data  = words[order[i]];
                    m_sel   = 2'(order[i]);
                    m_ack   = 4'(1 << order[i]);
                    m_valid = 1'b1;
                    m_ptr   = (order[i] + 1) % 4;
                    break;
                end
            end
        end
    endtask

    vec_t vecs [19];

    initial begin
        // Round-robin with all requesting, then skip-and-wrap on req=1001, then an idle row.
        vecs[0]  = mk(4'b1111, 1'b1, 1'b1, 8'h11, 2'd0, 4'b0001);
        vecs[1]  = mk(4'b1111, 1'b1, 1'b0, 8'h11, 2'd0, 4'b0000);
        vecs[2]  = mk(4'b1111, 1'b1, 1'b1, 8'h22, 2'd1, 4'b0010);
        vecs[3]  = mk(4'b1111, 1'b1, 1'b0, 8'h22, 2'd1, 4'b0000);
        vecs[4]  = mk(4'b1111, 1'b1, 1'b1, 8'h33, 2'd2, 4'b0100);
        vecs[5]  = mk(4'b1111, 1'b1, 1'b0, 8'h33, 2'd2, 4'b0000);
        vecs[6]  = mk(4'b1111, 1'b1, 1'b1, 8'h44, 2'd3, 4'b1000);
        vecs[7]  = mk(4'b1111, 1'b1, 1'b0, 8'h44, 2'd3, 4'b0000);
        vecs[8]  = mk(4'b1111, 1'b1, 1'b1, 8'h11, 2'd0, 4'b0001);
        vecs[9]  = mk(4'b1111, 1'b1, 1'b0, 8'h11, 2'd0, 4'b0000);
        vecs[10] = mk(4'b1001, 1'b1, 1'b1, 8'h44, 2'd3, 4'b1000);
        vecs[11] = mk(4'b1001, 1'b1, 1'b0, 8'h44, 2'd3, 4'b0000);
        vecs[12] = mk(4'b1001, 1'b1, 1'b1, 8'h11, 2'd0, 4'b0001);
        vecs[13] = mk(4'b1001, 1'b1, 1'b0, 8'h11, 2'd0, 4'b0000);
        vecs[14] = mk(4'b1001, 1'b1, 1'b1, 8'h44, 2'd3, 4'b1000);
        vecs[15] = mk(4'b1001, 1'b1, 1'b0, 8'h44, 2'd3, 4'b0000);
        vecs[16] = mk(4'b1001, 1'b1, 1'b1, 8'h11, 2'd0, 4'b0001);
        vecs[17] = mk(4'b1001, 1'b1, 1'b0, 8'h11, 2'd0, 4'b0000);
        vecs[18] = mk(4'b0000, 1'b1, 1'b0, 8'h11, 2'd0, 4'b0000);

        // Reset held with active requests.
        rst_n = 1'b0; req = 4'b1111; out_ready = 1'b1;
        a = 8'h11; b = 8'h22; c = 8'h33; d = 8'h44;
        #1;
        check_outs("reset_t0", 1'b0, 8'h00, 2'd0, 4'b0000);
        repeat (3) step();
        check_outs("reset_held", 1'b0, 8'h00, 2'd0, 4'b0000);
        #2 rst_n = 1'b1;

        foreach (vecs[i]) begin
            req = vecs[i].req; out_ready = vecs[i].rdy;
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                       vecs[i].exp_sel, vecs[i].exp_ack);
        end

        // Reset between edges, then a single request from c.
        rst_n = 1'b0;
        #1;
        check_outs("async_reset", 1'b0, 8'h00, 2'd0, 4'b0000);
        #1 rst_n = 1'b1;
        req = 4'b0100; c = 8'hC3; out_ready = 1'b1;
        step();
        check_outs("single_grant", 1'b1, 8'hC3, 2'd2, 4'b0100);
        req = 4'b0000;
        step();
        check_outs("single_drain", 1'b0, 8'hC3, 2'd2, 4'b0000);
        step();
        check_outs("single_idle", 1'b0, 8'hC3, 2'd2, 4'b0000);

        // Reset while BUSY discards the held word; pointer restarts at a.
        req = 4'b0100; c = 8'h33; out_ready = 1'b0;
        step();
        check_outs("busy_grant_c", 1'b1, 8'h33, 2'd2, 4'b0100);
        req = 4'b0000;
        #1 rst_n = 1'b0;
        #1;
        check_outs("busy_reset", 1'b0, 8'h00, 2'd0, 4'b0000);
        #1 rst_n = 1'b1;
        req = 4'b0010; b = 8'h22; out_ready = 1'b0;
        step();
        check_outs("post_reset_b", 1'b1, 8'h22, 2'd1, 4'b0010);

        // Backpressure: inputs toggle, the held word must not move.
        for (int i = 0; i < 5; i++) begin
            req = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
            c = 8'($urandom); d = 8'($urandom); out_ready = 1'b0;
            step();
            check_outs($sformatf("backpressure%0d", i), 1'b1, 8'h22, 2'd1, 4'b0000);
        end
        req = 4'b0000; out_ready = 1'b1;
        step();
        check_outs("bp_release", 1'b0, 8'h22, 2'd1, 4'b0000);

        // Randomized traffic against the model, starting from a fresh reset.
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 400; i++) begin
            req = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
            c = 8'($urandom); d = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            model_edge(req, out_ready, a, b, c, d);
            step();
            check_outs($sformatf("rand%0d", i), m_valid, m_data, m_sel, m_ack);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
